// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and widths for the regfile writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_COMMIT = 2'd2
  } wb_state_e;

  // One writeback request as seen on the requester side.
  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic              wen;
    logic [DATA_W-1:0] wdata;
  } wb_wr_t;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Combinational requester select: round-robin from ptr+1, or fixed lowest-index priority.
module rf_wb_arbiter_rr_arbiter #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned PTR_W    = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_c,
  output logic             valid_c
);

  int unsigned start;
  int unsigned idx;
  logic        found;

  // Fixed priority is round-robin with the scan always starting at index 0.
  always_comb begin
    grant_c = '0;
    found   = 1'b0;
    idx     = 0;
    start   = (ARB_MODE == 0) ? (32'(ptr_i) + 32'd1) : 32'd0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (start + k) % NREQ;
      if (!found && req_i[idx[PTR_W-1:0]]) begin
        grant_c[idx[PTR_W-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
  end

  assign valid_c = |req_i;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates NREQ writeback requesters onto the single regfile write port and
// hands each completed write to the commit logic with a req/ack handshake.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          wb_req_i,
  output logic [NREQ-1:0]          wb_ack_o,
  input  logic [NREQ*RD_W-1:0]     wb_rd_i,
  input  logic [NREQ-1:0]          wb_rd_wen_i,
  input  logic [NREQ*DATA_W-1:0]   wb_rd_wdata_i,
  output logic [RD_W-1:0]          rf_rd_o,
  output logic                     rf_rd_wen_o,
  output logic [DATA_W-1:0]        rf_rd_wdata_o,
  output logic                     commit_req_o,
  input  logic                     commit_ack_i,
  output logic [RD_W-1:0]          commit_rd_o,
  output logic [DATA_W-1:0]        commit_wdata_o
);

  localparam int unsigned PTR_W = ptr_width(NREQ);

  wb_state_e          state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic [RD_W-1:0]    rf_rd_q, rf_rd_d;
  logic               rf_wen_q, rf_wen_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;
  logic               commit_req_q, commit_req_d;
  logic [RD_W-1:0]    commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0]  commit_wdata_q, commit_wdata_d;

  logic [NREQ-1:0]    grant_c;
  logic               valid_c;
  wb_wr_t             sel_c;
  logic [PTR_W-1:0]   gidx_c;

  rf_wb_arbiter_rr_arbiter #(
    .NREQ     (NREQ),
    .ARB_MODE (ARB_MODE),
    .PTR_W    (PTR_W)
  ) u_arb (
    .req_i   (wb_req_i),
    .ptr_i   (ptr_q),
    .grant_c (grant_c),
    .valid_c (valid_c)
  );

  // Payload mux driven by the one-hot grant.
  always_comb begin
    sel_c  = '0;
    gidx_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        sel_c.rd    = wb_rd_i[i*RD_W +: RD_W];
        sel_c.wen   = wb_rd_wen_i[i];
        sel_c.wdata = wb_rd_wdata_i[i*DATA_W +: DATA_W];
        gidx_c      = PTR_W'(i);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    ack_d          = '0;
    rf_rd_d        = rf_rd_q;
    rf_wen_d       = 1'b0;
    rf_wdata_d     = rf_wdata_q;
    commit_req_d   = commit_req_q;
    commit_rd_d    = commit_rd_q;
    commit_wdata_d = commit_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_c) begin
          ack_d      = grant_c;
          rf_rd_d    = sel_c.rd;
          rf_wdata_d = sel_c.wdata;
          // x0 is hardwired zero: the write is still sequenced but never enabled.
          rf_wen_d   = sel_c.wen & (sel_c.rd != '0);
          if (ARB_MODE == 0) ptr_d = gidx_c;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        commit_req_d   = 1'b1;
        commit_rd_d    = rf_rd_q;
        commit_wdata_d = rf_wdata_q;
        state_d        = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (commit_ack_i) begin
          commit_req_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      ptr_q          <= PTR_W'(NREQ - 1);
      ack_q          <= '0;
      rf_rd_q        <= '0;
      rf_wen_q       <= 1'b0;
      rf_wdata_q     <= '0;
      commit_req_q   <= 1'b0;
      commit_rd_q    <= '0;
      commit_wdata_q <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      ack_q          <= ack_d;
      rf_rd_q        <= rf_rd_d;
      rf_wen_q       <= rf_wen_d;
      rf_wdata_q     <= rf_wdata_d;
      commit_req_q   <= commit_req_d;
      commit_rd_q    <= commit_rd_d;
      commit_wdata_q <= commit_wdata_d;
    end
  end

  assign wb_ack_o       = ack_q;
  assign rf_rd_o        = rf_rd_q;
  assign rf_rd_wen_o    = rf_wen_q;
  assign rf_rd_wdata_o  = rf_wdata_q;
  assign commit_req_o   = commit_req_q;
  assign commit_rd_o    = commit_rd_q;
  assign commit_wdata_o = commit_wdata_q;

endmodule
